// File: rtl/key_pkg.sv
// Shared definitions for the key loading path: default geometry, the
// loader state encoding and the word-to-slice mapping that the encrypt
// engine's key slicer also uses.
package key_pkg;

   localparam int KEY_WIDTH_DEF  = 512;
   localparam int WORD_WIDTH_DEF = 32;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } key_state_e;

   // Map the arrival position of a word (0 = first word of the key) onto
   // the slice of the key register it occupies.
   function automatic int unsigned slice_index(
      input int unsigned count,
      input int unsigned num_words,
      input bit          msw_first
   );
      if (msw_first) begin
         return num_words - 1 - count;
      end
      return count;
   endfunction

endpackage

// File: rtl/key_word_loader.sv
// Key word loader: packs a stream of WORD_WIDTH-bit words into a
// KEY_WIDTH-bit key, presents it with a valid flag and holds it until the
// cipher core acknowledges it. Supports abort/clear and back-to-back re-key.
module key_word_loader
   import key_pkg::*;
#(
   parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
   parameter int WORD_WIDTH = WORD_WIDTH_DEF,
   parameter bit MSW_FIRST  = 1'b0,
   localparam int NUM_WORDS = KEY_WIDTH / WORD_WIDTH,
   localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [WORD_WIDTH-1:0] iWord,
   input  logic                  iWord_valid,
   output logic                  oWord_ready,
   input  logic                  iClear,
   input  logic                  iKey_ack,
   output logic [KEY_WIDTH-1:0]  oKey,
   output logic                  oKey_valid,
   output logic [CNT_W-1:0]      oWord_count
);

   // Width of a bit offset into the key register.
   localparam int OFF_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

   // A key must split into a whole, non-zero number of words.
   if (KEY_WIDTH == 0 || WORD_WIDTH == 0 || (KEY_WIDTH % WORD_WIDTH) != 0) begin : g_bad_geometry
      $fatal(1, "key_word_loader: KEY_WIDTH must be a non-zero multiple of WORD_WIDTH");
   end

   key_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic                 accept;
   logic [OFF_W-1:0]     slice_base;

   // Ready depends only on registered state and the abort input, never on
   // iWord_valid, so upstream can safely wait on it.
   assign oWord_ready = (state_q == ST_FILL) && !iClear;
   assign accept      = iWord_valid && oWord_ready;

   assign oKey        = key_q;
   assign oKey_valid  = (state_q == ST_FULL);
   assign oWord_count = cnt_q;

   // Next-state, counter and slice write; clear beats ack beats accept.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_d      = key_q;
      slice_base = OFF_W'(slice_index(32'(cnt_q), NUM_WORDS, MSW_FIRST) * WORD_WIDTH);

      if (iClear) begin
         state_d = ST_FILL;
         cnt_d   = '0;
         key_d   = '0;
      end else if (state_q == ST_FULL) begin
         // Key is frozen; only an acknowledge releases it. Old contents stay
         // in place until the next fill overwrites them slice by slice.
         if (iKey_ack) begin
            state_d = ST_FILL;
            cnt_d   = '0;
         end
      end else if (accept) begin
         key_d[slice_base +: WORD_WIDTH] = iWord;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            state_d = ST_FULL;
         end
      end
   end

   // State, count and key registers with asynchronous reset.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         key_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
      end
   end

endmodule

// File: doc/key_word_loader.md
# key_word_loader

Parametrised key-loading front end for the XOR cipher datapath. It accepts key material as a stream of WORD_WIDTH-bit words over a valid/ready handshake and packs them into a KEY_WIDTH-bit key register in a selectable word order. It presents the complete key with a valid flag and holds it stable until the cipher core acknowledges it. The block sits between the serial key deserialiser and the encrypt engine, and adds backpressure, abort/clear and re-key capability.

## Interface
Parameters:
- KEY_WIDTH, 512, width of the assembled key in bits; must be a non-zero multiple of WORD_WIDTH.
- WORD_WIDTH, 32, width of one incoming key word.
- MSW_FIRST, 0, word order: 0 = first word lands in bits [WORD_WIDTH-1:0]; 1 = first word lands in the top slice [KEY_WIDTH-1 -: WORD_WIDTH].

Derived: NUM_WORDS = KEY_WIDTH/WORD_WIDTH; CNT_W = $clog2(NUM_WORDS+1).

Ports:
- iClk, in, 1, single clock; all state updates on the rising edge.
- iRst, in, 1, asynchronous active-high reset.
- iWord, in, WORD_WIDTH, key word.
- iWord_valid, in, 1, iWord is valid this cycle.
- oWord_ready, out, 1, block accepts a word this cycle.
- iClear, in, 1, synchronous abort: discard partial or complete key.
- iKey_ack, in, 1, consumer has latched oKey; release for re-key.
- oKey, out, KEY_WIDTH, assembled key.
- oKey_valid, out, 1, oKey is complete and stable.
- oWord_count, out, CNT_W, number of words accepted into the current key (0..NUM_WORDS).

## Operation
- States: FILL and FULL. Reset state is FILL.
- Reset values: oKey = 0, oWord_count = 0, oKey_valid = 0, state = FILL, so oWord_ready = 1.
- FILL behaviour:
  - oWord_ready = 1.
  - An accept occurs when iWord_valid && oWord_ready.
  - On accept, iWord is written to slice index k = oWord_count. With MSW_FIRST = 0 the slice is bits [k*WORD_WIDTH +: WORD_WIDTH]. With MSW_FIRST = 1 it is bits [(NUM_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH].
  - On accept, oWord_count increments.
  - The accept of word NUM_WORDS-1 sets oWord_count = NUM_WORDS, oKey_valid = 1 and moves the state to FULL.
- FULL behaviour:
  - oWord_ready = 0. iWord_valid is ignored and oKey does not change.
  - iKey_ack moves the state to FILL, with oKey_valid = 0 and oWord_count = 0.
  - oKey keeps its old contents until the next fill overwrites it slice by slice.
- iKey_ack in FILL is ignored.
- iClear in either state:
  - oKey = 0, oWord_count = 0, oKey_valid = 0, state = FILL.
  - Any word offered in the same cycle is not accepted.
- Simultaneous-event priority: iRst > iClear > iKey_ack > word accept.
- Slices not yet written in a fill keep their previous value. Consumers must only use oKey while oKey_valid = 1.
- Reset mid-fill returns the block to its reset values immediately; no partial key survives.
- Widths:
  - oWord_count never exceeds NUM_WORDS.
  - Slice index arithmetic uses CNT_W bits and never wraps within a legal operation.

## Timing
- oWord_ready is decoded combinationally from the registered state and iClear. It deasserts in any cycle where iClear = 1. It has no dependency on iWord_valid.
- Accept latency: the word is visible in oKey, and oWord_count has incremented, after the accepting edge.
- oKey_valid rises on the same edge that accepts the final word. A full key needs a minimum of NUM_WORDS cycles from FILL with oWord_count = 0.
- iKey_ack takes effect on the next edge. oWord_ready is 1 in the following cycle, so back-to-back keys run with one cycle of gap.
- iClear takes effect on the next edge; oKey reads 0 in the following cycle.
- Asynchronous iRst clears all registers without a clock. Deassertion is synchronised externally.

## Structure
- Shared package key_pkg holds:
  - the KEY_WIDTH and WORD_WIDTH defaults;
  - the state encoding constants ST_FILL and ST_FULL;
  - a function for computing the slice index from count and MSW_FIRST, shared with the encrypt engine's key slicer.
- Single module, no sub-modules. The counter, state register and slice write are all local.
- Elaboration-time check: KEY_WIDTH % WORD_WIDTH != 0 is a fatal error.

## Test plan
- Default parameters, MSW_FIRST = 0, words 0x00000001..0x00000010 with continuous valid:
  - After the 16th accept, oKey[31:0] = 0x1 and oKey[511:480] = 0x10.
  - oKey_valid = 1, oWord_count = 16, oWord_ready = 0.
- Same stimulus with MSW_FIRST = 1: oKey[511:480] = 0x1, oKey[31:0] = 0x10.
- Backpressure: hold iWord_valid = 1 with 0xDEADBEEF while FULL for 10 cycles -> oKey is unchanged. Then pulse iKey_ack -> oKey_valid = 0 and oWord_count = 0 next cycle, and the next accepted word overwrites slice 0.
- Clear after 5 words with iClear and iWord_valid asserted together -> that word is not accepted, oKey = 0 and oWord_count = 0. A subsequent full 16-word fill completes normally.
- KEY_WIDTH = 64, WORD_WIDTH = 8, bytes 0xA0..0xA7 -> oKey = 0xA7A6A5A4A3A2A1A0 and oKey_valid = 1 after the 8th accept. iKey_ack and iClear in the same cycle -> clear behaviour (oKey = 0).
- Assert iRst asynchronously (mid-cycle) after 7 words -> all outputs return to reset values before the next edge, and the next fill starts at slice 0.
